// File: rtl/interface_hcsr04_multi_pkg.sv
// Shared constants for the multi-channel HC-SR04 interface: FSM state codes,
// BCD layout, the error code, and a saturating BCD increment.
package interface_hcsr04_pkg;

    localparam int          BCD_DIG_W   = 4;
    localparam int          BCD_W       = 3 * BCD_DIG_W;
    localparam logic [11:0] BCD_MAX     = 12'h999;
    localparam logic [11:0] MEDIDA_ERRO = 12'hFFF;

    typedef enum logic [3:0] {
        ST_INICIAL       = 4'd0,
        ST_PREPARACAO    = 4'd1,
        ST_ENVIA_TRIGGER = 4'd2,
        ST_ESPERA_ECHO   = 4'd3,
        ST_MEDE          = 4'd4,
        ST_ARMAZENA      = 4'd5,
        ST_TIMEOUT       = 4'd6,
        ST_INTERVALO     = 4'd7,
        ST_FINAL         = 4'd8
    } estado_t;

    // +1 on a 3-digit BCD value; sticks at 999 instead of wrapping.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != BCD_MAX) begin
            if (r[3:0] != 4'd9) begin
                r[3:0] = r[3:0] + 4'd1;
            end else begin
                r[3:0] = 4'd0;
                if (r[7:4] != 4'd9) begin
                    r[7:4] = r[7:4] + 4'd1;
                end else begin
                    r[7:4]  = 4'd0;
                    r[11:8] = r[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/interface_hcsr04_multi_if.sv
// Request/result bundle between the measurement-request logic and the
// sensor interface, plus the sensor pins themselves.
interface interface_hcsr04_multi_if #(
    parameter int N_CH = 2
);
    logic                   medir;
    logic [N_CH-1:0]        echo;
    logic [N_CH-1:0]        trigger;
    logic [12*N_CH-1:0]     medida;
    logic [N_CH-1:0]        erro;
    logic                   pronto;
    logic [3:0]             db_estado;
    logic [2:0]             db_canal;

    modport master (
        output medir, echo,
        input  trigger, medida, erro, pronto, db_estado, db_canal
    );

    modport slave (
        input  medir, echo,
        output trigger, medida, erro, pronto, db_estado, db_canal
    );
endinterface

// File: rtl/interface_hcsr04_multi_contador.sv
// Echo-width to centimetre converter: tick divider feeding a saturating
// 3-digit BCD counter, with round-half-up applied when the echo ends.
module contador_cm_bcd
    import interface_hcsr04_pkg::*;
#(
    parameter int CYC_PER_CM = 2941
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             zera,
    input  logic             conta,
    input  logic             fim,
    output logic [BCD_W-1:0] bcd
);

    localparam int TICK_W = $clog2(CYC_PER_CM);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CYC_PER_CM - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CYC_PER_CM / 2);

    logic [TICK_W-1:0] tick;

    // Count echo-high cycles; a full tick period is one cm, a residual of
    // at least half a period rounds up once the echo falls.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick <= '0;
            bcd  <= '0;
        end else if (zera) begin
            tick <= '0;
            bcd  <= '0;
        end else if (fim) begin
            if (tick >= TICK_HALF) bcd <= bcd_inc(bcd);
            tick <= '0;
        end else if (conta) begin
            if (tick == TICK_LAST) begin
                tick <= '0;
                bcd  <= bcd_inc(bcd);
            end else begin
                tick <= tick + 1'b1;
            end
        end
    end

endmodule

// File: rtl/interface_hcsr04_multi.sv
// Round-robin HC-SR04 driver: one medir request triggers and measures every
// channel in turn, with a quiet gap between channels to avoid crosstalk.
module interface_hcsr04_multi
    import interface_hcsr04_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int N_CH        = 2,
    parameter int CYC_PER_CM  = 2941,
    parameter int TRIG_CYC    = 500,
    parameter int TIMEOUT_CYC = 1_500_000,
    parameter int GAP_CYC     = 50_000
) (
    input  logic                     clock,
    input  logic                     reset,
    interface_hcsr04_multi_if.slave  bus
);

    if (N_CH < 1 || N_CH > 8 || CLK_HZ <= 0 || CYC_PER_CM < 2 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("interface_hcsr04_multi: parameter out of range");
    end

    localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC)
                           ? ((TIMEOUT_CYC > TRIG_CYC) ? TIMEOUT_CYC : TRIG_CYC)
                           : ((GAP_CYC > TRIG_CYC) ? GAP_CYC : TRIG_CYC);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t TRIG_LAST  = cnt_t'(TRIG_CYC - 1);
    localparam cnt_t ESPERA_LST = cnt_t'(TIMEOUT_CYC - 1);
    // The first high cycle is spent in espera_echo, so mede reaches the
    // high-time limit one count earlier.
    localparam cnt_t MEDE_LST   = cnt_t'(TIMEOUT_CYC - 2);
    localparam cnt_t GAP_LAST   = cnt_t'(GAP_CYC - 1);

    estado_t            state, nxt;
    cnt_t               cnt;
    logic [2:0]         ch;
    logic [N_CH-1:0]    echo_ff1, echo_s;
    logic [7:0]         echo_pad;
    logic               echo_cur;
    logic               zera, conta, fim, wr_ok, wr_err;
    logic [BCD_W-1:0]   bcd;
    logic [12*N_CH-1:0] medida_q;
    logic [N_CH-1:0]    erro_q;

    assign echo_pad      = 8'(echo_s);
    assign echo_cur      = echo_pad[ch];
    assign bus.medida    = medida_q;
    assign bus.erro      = erro_q;
    assign bus.db_estado = state;
    assign bus.db_canal  = ch;

    contador_cm_bcd #(.CYC_PER_CM(CYC_PER_CM)) u_contador (
        .clock (clock),
        .reset (reset),
        .zera  (zera),
        .conta (conta),
        .fim   (fim),
        .bcd   (bcd)
    );

    // Two-flop synchroniser on every echo pin.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            echo_ff1 <= '0;
            echo_s   <= '0;
        end else begin
            echo_ff1 <= bus.echo;
            echo_s   <= echo_ff1;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_INICIAL;
        else        state <= nxt;
    end

    // Next-state logic.
    always_comb begin
        nxt = state;
        case (state)
            ST_INICIAL:       if (bus.medir) nxt = ST_PREPARACAO;
            ST_PREPARACAO:    nxt = ST_ENVIA_TRIGGER;
            ST_ENVIA_TRIGGER: if (cnt == TRIG_LAST) nxt = ST_ESPERA_ECHO;
            ST_ESPERA_ECHO: begin
                if (echo_cur)                 nxt = ST_MEDE;
                else if (cnt == ESPERA_LST)   nxt = ST_TIMEOUT;
            end
            ST_MEDE: begin
                if (!echo_cur)                nxt = ST_ARMAZENA;
                else if (cnt == MEDE_LST)     nxt = ST_TIMEOUT;
            end
            ST_ARMAZENA, ST_TIMEOUT: nxt = ST_INTERVALO;
            ST_INTERVALO: begin
                if (cnt == GAP_LAST)
                    nxt = (ch == 3'(N_CH - 1)) ? ST_FINAL : ST_ENVIA_TRIGGER;
            end
            ST_FINAL: nxt = ST_INICIAL;
            default:  nxt = ST_INICIAL;
        endcase
    end

    // Output decode: trigger select, converter control, result strobes.
    always_comb begin
        bus.trigger = '0;
        bus.pronto  = 1'b0;
        zera        = 1'b0;
        conta       = 1'b0;
        fim         = 1'b0;
        wr_ok       = 1'b0;
        wr_err      = 1'b0;
        case (state)
            ST_PREPARACAO:    zera = 1'b1;
            ST_ENVIA_TRIGGER: begin
                zera        = 1'b1;
                bus.trigger = N_CH'(8'd1 << ch);
            end
            ST_ESPERA_ECHO:   conta = echo_cur;
            ST_MEDE: begin
                conta = echo_cur;
                fim   = !echo_cur;
            end
            ST_ARMAZENA:      wr_ok  = 1'b1;
            ST_TIMEOUT:       wr_err = 1'b1;
            ST_FINAL:         bus.pronto = 1'b1;
            default: ;
        endcase
    end

    // Shared phase counter: trigger width, echo wait/high time, inter-channel gap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                              cnt <= '0;
        else if (nxt != state || state == ST_INICIAL) cnt <= '0;
        else                                     cnt <= cnt + 1'b1;
    end

    // Channel pointer: restart at 0 per scan, advance after each gap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                                             ch <= '0;
        else if (state == ST_PREPARACAO)                        ch <= '0;
        else if (state == ST_INTERVALO && nxt == ST_ENVIA_TRIGGER) ch <= ch + 3'd1;
    end

    // Per-channel result registers; only the channel being serviced changes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            medida_q <= '0;
            erro_q   <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (ch == 3'(k)) begin
                    if (wr_ok) begin
                        medida_q[12*k +: 12] <= bcd;
                        erro_q[k]            <= 1'b0;
                    end else if (wr_err) begin
                        medida_q[12*k +: 12] <= MEDIDA_ERRO;
                        erro_q[k]            <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
